// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared state encoding, stall bit positions and pipeline stage indices
package hazard_ctrl_pkg;
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    HAZARD   = 3'd1,
    MEM_WAIT = 3'd2,
    FLUSH    = 3'd3,
    SLEEP    = 3'd4
  } state_t;
  localparam int STALL_RAW   = 0;
  localparam int STALL_LOAD  = 1;
  localparam int STALL_MEM   = 2;
  localparam int STALL_SLP   = 3;
  localparam int STALL_FLUSH = 4;
  localparam int EX = 0;
  localparam int MA = 1;
  localparam int WB = 2;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational RAW/load-use comparator of decode sources against in-flight destinations
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic            dec_valid,
  input  logic [2:0]      dec_src_a,
  input  logic [2:0]      dec_src_b,
  input  logic            dec_src_a_used,
  input  logic            dec_src_b_used,
  input  logic [2:0][2:0] pipe_dst,
  input  logic [2:0]      pipe_wr,
  input  logic [2:0]      pipe_is_load,
  output logic            raw,
  output logic            load
);
  logic [2:0] match;
  logic any_match;
  logic load_match;
  always_comb begin
    match[EX] = pipe_wr[EX] && ((dec_src_a_used && dec_src_a == pipe_dst[EX]) || (dec_src_b_used && dec_src_b == pipe_dst[EX]));
    match[MA] = pipe_wr[MA] && ((dec_src_a_used && dec_src_a == pipe_dst[MA]) || (dec_src_b_used && dec_src_b == pipe_dst[MA]));
    match[WB] = pipe_wr[WB] && ((dec_src_a_used && dec_src_a == pipe_dst[WB]) || (dec_src_b_used && dec_src_b == pipe_dst[WB]));
    any_match = dec_valid && |match;
    load_match = |(match & pipe_is_load);
    load = any_match && load_match;
    raw = any_match && !load_match;
  end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline stall/clear/fetch sequencing FSM; HAZARD_STATS_EN adds stall and flush statistics counters
module hazard_controller
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dec_valid,
  input  logic [2:0]      dec_src_a,
  input  logic [2:0]      dec_src_b,
  input  logic            dec_src_a_used,
  input  logic            dec_src_b_used,
  input  logic            dec_is_slp,
  input  logic [2:0][2:0] pipe_dst,
  input  logic [2:0]      pipe_wr,
  input  logic [2:0]      pipe_is_load,
  input  logic            mem_req,
  input  logic            mem_ack,
  input  logic            branch_fail,
  input  logic            wake,
  output logic [7:0]      stall_o,
  output logic            clear_o,
  output logic            fetch_en_o,
  output logic [2:0]      state_o,
  output logic            mem_err_o,
  output logic [15:0]     stall_cycles_o,
  output logic [15:0]     flush_count_o
);
  localparam logic [3:0] FL = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TM = 8'(MEM_TIMEOUT - 1);
  state_t state, nxt;
  logic [3:0] fcnt, fcnt_n;
  logic [7:0] tcnt, tcnt_n;
  logic pend, pend_n, err_n, fl_entry, raw, load, active;
  hazard_detect u_detect (
    .dec_valid      (dec_valid),
    .dec_src_a      (dec_src_a),
    .dec_src_b      (dec_src_b),
    .dec_src_a_used (dec_src_a_used),
    .dec_src_b_used (dec_src_b_used),
    .pipe_dst       (pipe_dst),
    .pipe_wr        (pipe_wr),
    .pipe_is_load   (pipe_is_load),
    .raw            (raw),
    .load           (load)
  );
  always_comb begin
    nxt = state;
    err_n = 1'b0;
    case (state)
      RUN, HAZARD: nxt = branch_fail ? FLUSH : (mem_req && !mem_ack) ? MEM_WAIT : (raw || load) ? HAZARD : (dec_valid && dec_is_slp) ? SLEEP : RUN;
      MEM_WAIT: begin
        err_n = !mem_ack && tcnt == TM;
        nxt = (mem_ack || err_n) ? ((pend || branch_fail) ? FLUSH : RUN) : MEM_WAIT;
      end
      FLUSH: nxt = (branch_fail || fcnt != 4'd0) ? FLUSH : RUN;
      SLEEP: nxt = branch_fail ? FLUSH : wake ? RUN : SLEEP;
      default: nxt = RUN;
    endcase
    fl_entry = nxt == FLUSH && (state != FLUSH || branch_fail);
    fcnt_n = fl_entry ? FL : fcnt - 4'(fcnt != 4'd0);
    tcnt_n = (state == MEM_WAIT && nxt == MEM_WAIT) ? tcnt + 8'd1 : 8'd0;
    pend_n = state == MEM_WAIT && nxt == MEM_WAIT && (pend || branch_fail);
    active = state == RUN || state == HAZARD;
    stall_o = 8'd0;
    stall_o[STALL_RAW] = raw && active;
    stall_o[STALL_LOAD] = load && active;
    stall_o[STALL_MEM] = state == MEM_WAIT;
    stall_o[STALL_SLP] = state == SLEEP;
    stall_o[STALL_FLUSH] = state == FLUSH;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      fcnt <= 4'd0;
      tcnt <= 8'd0;
      pend <= 1'b0;
      mem_err_o <= 1'b0;
    end else begin
      state <= nxt;
      fcnt <= fcnt_n;
      tcnt <= tcnt_n;
      pend <= pend_n;
      mem_err_o <= err_n;
    end
  end
  assign clear_o = state == FLUSH;
  assign fetch_en_o = ~|stall_o;
  assign state_o = state;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_count;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 16'd0;
      flush_count <= 16'd0;
    end else begin
      stall_cycles <= (|stall_o && stall_cycles != 16'hFFFF) ? stall_cycles + 16'd1 : stall_cycles;
      flush_count <= (fl_entry && flush_count != 16'hFFFF) ? flush_count + 16'd1 : flush_count;
    end
  end
  assign stall_cycles_o = stall_cycles;
  assign flush_count_o = flush_count;
`else
  assign stall_cycles_o = 16'd0;
  assign flush_count_o = 16'd0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed self-checking bench for hazard_controller
module tb_hazard_controller;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dec_valid, dec_src_a_used, dec_src_b_used, dec_is_slp;
  logic [2:0] dec_src_a, dec_src_b, pipe_wr, pipe_is_load;
  logic [2:0][2:0] pipe_dst;
  logic mem_req, mem_ack, branch_fail, wake;
  logic [7:0] stall_o;
  logic clear_o, fetch_en_o, mem_err_o;
  logic [2:0] state_o;
  logic [15:0] stall_cycles_o, flush_count_o;
  int checks = 0;
  int errors = 0;

  hazard_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(15)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dec_valid      (dec_valid),
    .dec_src_a      (dec_src_a),
    .dec_src_b      (dec_src_b),
    .dec_src_a_used (dec_src_a_used),
    .dec_src_b_used (dec_src_b_used),
    .dec_is_slp     (dec_is_slp),
    .pipe_dst       (pipe_dst),
    .pipe_wr        (pipe_wr),
    .pipe_is_load   (pipe_is_load),
    .mem_req        (mem_req),
    .mem_ack        (mem_ack),
    .branch_fail    (branch_fail),
    .wake           (wake),
    .stall_o        (stall_o),
    .clear_o        (clear_o),
    .fetch_en_o     (fetch_en_o),
    .state_o        (state_o),
    .mem_err_o      (mem_err_o),
    .stall_cycles_o (stall_cycles_o),
    .flush_count_o  (flush_count_o)
  );

  always #5 clk = ~clk;

  task step;
    @(posedge clk);
    #2;
  endtask

  task idle;
    dec_valid = 0; dec_src_a = 0; dec_src_b = 0; dec_src_a_used = 0; dec_src_b_used = 0;
    dec_is_slp = 0; pipe_dst = '0; pipe_wr = 0; pipe_is_load = 0;
    mem_req = 0; mem_ack = 0; branch_fail = 0; wake = 0;
  endtask

  task ex_hazard;
    dec_valid = 1; dec_src_a = 3; dec_src_a_used = 1; pipe_dst[0] = 3; pipe_wr = 3'b001;
  endtask

  task test_reset;
    idle;
    reset_n = 0;
    #1;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
    checks++; if ({stall_o, clear_o, fetch_en_o, mem_err_o} !== {8'h00, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL reset_outputs stall %h clear %b fetch %b err %b", stall_o, clear_o, fetch_en_o, mem_err_o); end
    checks++; if ({stall_cycles_o, flush_count_o} !== 32'd0) begin errors++; $display("FAIL reset_stats got %h %h want 0 0", stall_cycles_o, flush_count_o); end
    step;
    reset_n = 1;
    step;
  endtask

  task test_raw;
    ex_hazard;
    #1;
    checks++; if ({stall_o, fetch_en_o} !== {8'h01, 1'b0}) begin errors++; $display("FAIL raw_ex stall %h fetch %b want 01 0", stall_o, fetch_en_o); end
    step;
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL raw_state got %0d want 1", state_o); end
    pipe_dst[0] = 0; pipe_dst[1] = 3; pipe_wr = 3'b010;
    #1;
    checks++; if (stall_o !== 8'h01) begin errors++; $display("FAIL raw_ma got %h want 01", stall_o); end
    step;
    pipe_dst[1] = 0; pipe_dst[2] = 3; pipe_wr = 3'b100;
    step;
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL raw_wb_state got %0d want 1", state_o); end
    pipe_wr = 0;
    #1;
    checks++; if ({stall_o, fetch_en_o} !== {8'h00, 1'b1}) begin errors++; $display("FAIL raw_clear stall %h fetch %b want 00 1", stall_o, fetch_en_o); end
    step;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL raw_return got %0d want 0", state_o); end
    idle;
  endtask

  task test_load;
    dec_valid = 1; dec_src_b = 5; dec_src_b_used = 1;
    pipe_dst[1] = 5; pipe_wr = 3'b010; pipe_is_load = 3'b010;
    #1;
    checks++; if (stall_o !== 8'h02) begin errors++; $display("FAIL load_ma got %h want 02", stall_o); end
    pipe_dst[0] = 5; pipe_wr = 3'b011;
    #1;
    checks++; if (stall_o !== 8'h02) begin errors++; $display("FAIL load_mixed got %h want 02", stall_o); end
    pipe_dst[0] = 4; pipe_dst[1] = 4; dec_src_a = 4; dec_src_a_used = 0;
    #1;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL load_nomatch got %h want 00", stall_o); end
    pipe_dst[1] = 5; dec_valid = 0;
    #1;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL load_invalid got %h want 00", stall_o); end
    idle;
    step;
  endtask

  task test_flush;
    branch_fail = 1;
    #1;
    checks++; if (clear_o !== 1'b0) begin errors++; $display("FAIL flush_c0 clear %b want 0", clear_o); end
    step;
    branch_fail = 0;
    ex_hazard;
    #1;
    checks++; if ({clear_o, state_o, stall_o, fetch_en_o} !== {1'b1, 3'd3, 8'h10, 1'b0}) begin errors++; $display("FAIL flush_c1 clear %b state %0d stall %h fetch %b", clear_o, state_o, stall_o, fetch_en_o); end
    idle;
    step;
    checks++; if (clear_o !== 1'b1) begin errors++; $display("FAIL flush_c2 clear %b want 1", clear_o); end
    step;
    checks++; if ({clear_o, state_o} !== {1'b0, 3'd0}) begin errors++; $display("FAIL flush_c3 clear %b state %0d want 0 0", clear_o, state_o); end
    branch_fail = 1;
    step;
    checks++; if (clear_o !== 1'b1) begin errors++; $display("FAIL restart_c1 clear %b want 1", clear_o); end
    step;
    branch_fail = 0;
    checks++; if (clear_o !== 1'b1) begin errors++; $display("FAIL restart_c2 clear %b want 1", clear_o); end
    step;
    checks++; if (clear_o !== 1'b1) begin errors++; $display("FAIL restart_c3 clear %b want 1", clear_o); end
    step;
    checks++; if ({clear_o, state_o} !== {1'b0, 3'd0}) begin errors++; $display("FAIL restart_c4 clear %b state %0d want 0 0", clear_o, state_o); end
  endtask

  task test_mem_timeout;
    mem_req = 1;
    #1;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL mem_req_c0 stall %h want 00", stall_o); end
    step;
    mem_req = 0;
    for (int k = 0; k < 15; k++) begin
      checks++; if ({state_o, stall_o, fetch_en_o, mem_err_o} !== {3'd2, 8'h04, 1'b0, 1'b0}) begin errors++; $display("FAIL mem_wait_%0d state %0d stall %h fetch %b err %b", k, state_o, stall_o, fetch_en_o, mem_err_o); end
      step;
    end
    checks++; if ({state_o, stall_o, mem_err_o} !== {3'd0, 8'h00, 1'b1}) begin errors++; $display("FAIL mem_timeout state %0d stall %h err %b want 0 00 1", state_o, stall_o, mem_err_o); end
    step;
    checks++; if (mem_err_o !== 1'b0) begin errors++; $display("FAIL mem_err_pulse err %b want 0", mem_err_o); end
  endtask

  task test_mem_ack;
    mem_req = 1; mem_ack = 1;
    #1;
    checks++; if (stall_o !== 8'h00) begin errors++; $display("FAIL ack_same stall %h want 00", stall_o); end
    step;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL ack_same_state got %0d want 0", state_o); end
    mem_ack = 0;
    step;
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL ack_wait_state got %0d want 2", state_o); end
    mem_req = 0; mem_ack = 1;
    step;
    mem_ack = 0;
    checks++; if ({state_o, stall_o, mem_err_o} !== {3'd0, 8'h00, 1'b0}) begin errors++; $display("FAIL ack_done state %0d stall %h err %b", state_o, stall_o, mem_err_o); end
  endtask

  task test_mem_branch;
    mem_req = 1;
    step;
    mem_req = 0;
    branch_fail = 1;
    step;
    branch_fail = 0;
    checks++; if ({state_o, clear_o} !== {3'd2, 1'b0}) begin errors++; $display("FAIL pend_c2 state %0d clear %b want 2 0", state_o, clear_o); end
    step;
    step;
    mem_ack = 1;
    checks++; if ({state_o, stall_o} !== {3'd2, 8'h04}) begin errors++; $display("FAIL pend_ackcycle state %0d stall %h want 2 04", state_o, stall_o); end
    step;
    mem_ack = 0;
    checks++; if ({state_o, clear_o} !== {3'd3, 1'b1}) begin errors++; $display("FAIL pend_flush state %0d clear %b want 3 1", state_o, clear_o); end
    step;
    step;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL pend_done state %0d want 0", state_o); end
  endtask

  task test_sleep;
    dec_valid = 1; dec_is_slp = 1;
    #1;
    checks++; if ({stall_o, fetch_en_o} !== {8'h00, 1'b1}) begin errors++; $display("FAIL slp_c0 stall %h fetch %b want 00 1", stall_o, fetch_en_o); end
    step;
    idle;
    checks++; if ({state_o, stall_o, fetch_en_o} !== {3'd4, 8'h08, 1'b0}) begin errors++; $display("FAIL slp_state state %0d stall %h fetch %b", state_o, stall_o, fetch_en_o); end
    step;
    wake = 1;
    step;
    wake = 0;
    checks++; if ({state_o, fetch_en_o} !== {3'd0, 1'b1}) begin errors++; $display("FAIL slp_wake state %0d fetch %b want 0 1", state_o, fetch_en_o); end
    ex_hazard; dec_is_slp = 1;
    step;
    idle;
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL slp_hazard state %0d want 1", state_o); end
    step;
    dec_valid = 1; dec_is_slp = 1;
    step;
    idle;
    branch_fail = 1; wake = 1;
    step;
    branch_fail = 0; wake = 0;
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL slp_branch state %0d want 3", state_o); end
    step;
    step;
    dec_valid = 1; dec_is_slp = 1;
    step;
    idle;
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL slp_again state %0d want 4", state_o); end
    #1;
    reset_n = 0;
    #1;
    checks++; if ({state_o, fetch_en_o, stall_o} !== {3'd0, 1'b1, 8'h00}) begin errors++; $display("FAIL slp_reset state %0d fetch %b stall %h", state_o, fetch_en_o, stall_o); end
    @(negedge clk);
    reset_n = 1;
    step;
  endtask

  task test_stats;
    reset_n = 0;
    step;
    reset_n = 1;
    ex_hazard;
    step;
    step;
    step;
    idle;
    #1;
    checks++; if (stall_cycles_o !== (STATS ? 16'd3 : 16'd0)) begin errors++; $display("FAIL stat_stall got %0d want %0d", stall_cycles_o, STATS ? 3 : 0); end
    branch_fail = 1;
    step;
    step;
    branch_fail = 0;
    checks++; if (flush_count_o !== (STATS ? 16'd2 : 16'd0)) begin errors++; $display("FAIL stat_flush got %0d want %0d", flush_count_o, STATS ? 2 : 0); end
    reset_n = 0;
    #1;
    checks++; if ({clear_o, state_o, flush_count_o} !== {1'b0, 3'd0, 16'd0}) begin errors++; $display("FAIL flush_reset clear %b state %0d flush %0d", clear_o, state_o, flush_count_o); end
    @(negedge clk);
    reset_n = 1;
    step;
  endtask

  initial begin
    test_reset;
    test_raw;
    test_load;
    test_flush;
    test_mem_timeout;
    test_mem_ack;
    test_mem_branch;
    test_sleep;
    test_stats;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
